// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit that owns the MIPS HI/LO registers.
// Handles MULTU/MULT/DIVU/DIV (op 00/01/10/11) over WIDTH+1 busy cycles, plus
// MTHI/MTLO writes while idle.
// Optional feature: define MIPS_MULDIV_DIVZERO_EN to add the dz output and a
// one-cycle early completion for divides by zero.
//
// Handshake: start is sampled only while busy=0. An accepted start makes busy=1
// on the following cycle; busy drops and done pulses for exactly one cycle when
// hi/lo hold the new result. A start seen while busy=1 is dropped, not queued.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MIPS_MULDIV_DIVZERO_EN
    ,
    output logic             dz
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // product/quotient needs negation
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic [WIDTH-1:0]   opnd_q, opnd_d;         // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc_q, acc_d;           // {upper, lower} working register
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
`ifdef MIPS_MULDIV_DIVZERO_EN
    logic               dz_q, dz_d;
    logic               dz_pend_q, dz_pend_d;
`endif

    // Operand magnitudes; unsigned ops pass operands through untouched.
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign sign_a = op[0] & a[WIDTH-1];
    assign sign_b = op[0] & b[WIDTH-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: acc = {partial remainder, dividend/quotient bits}.
    // The shifted remainder can reach WIDTH+1 bits, so the compare is done at
    // that width; when it succeeds the true difference is below the divisor,
    // so its low WIDTH bits are the whole answer.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    // Sign correction applied on the FIX edge.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MIPS_MULDIV_DIVZERO_EN
        dz_d      = 1'b0;
        dz_pend_d = dz_pend_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    count_d   = '0;
                    state_d   = S_RUN;
                    if (op[1]) begin
                        opnd_d = mag_b;
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                    end
`ifdef MIPS_MULDIV_DIVZERO_EN
                    dz_pend_d = 1'b0;
                    // Divide by zero completes on the very next edge: the FIX
                    // edge restores the dividend sign into hi, lo is forced.
                    if (op[1] && (b == '0)) begin
                        dz_pend_d = 1'b1;
                        acc_d     = {mag_a, {WIDTH{1'b1}}};
                        state_d   = S_FIX;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    count_d = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
`ifdef MIPS_MULDIV_DIVZERO_EN
                if (dz_pend_q) lo_d = '1;
                dz_d      = dz_pend_q;
                dz_pend_d = 1'b0;
`endif
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MIPS_MULDIV_DIVZERO_EN
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MIPS_MULDIV_DIVZERO_EN
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MIPS_MULDIV_DIVZERO_EN
    assign dz   = dz_q;
`endif

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed vectors for mips_muldiv (WIDTH=32). The driver
// pushes the expected {hi,lo}, completion edge and dz flag per operation; a
// negedge monitor pops and compares whenever done is high.
module tb_mips_muldiv;

    localparam int W = 32;
`ifdef MIPS_MULDIV_DIVZERO_EN
    localparam bit             DZ_EN      = 1'b1;
    localparam logic [W-1:0]   DIVZ_NEG_LO = 32'hFFFF_FFFF;
`else
    localparam bit             DZ_EN      = 1'b0;
    localparam logic [W-1:0]   DIVZ_NEG_LO = 32'h0000_0001;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         hi_we, lo_we;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MIPS_MULDIV_DIVZERO_EN
    logic         dz;
`endif

    mips_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
`ifdef MIPS_MULDIV_DIVZERO_EN
        ,
        .dz    (dz)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    int             exp_edge_q[$];
    bit             exp_dz_q[$];
    int             n_checks = 0;
    int             n_pass   = 0;
    logic [W-1:0]   model_hi = '0;
    logic [W-1:0]   model_lo = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    logic [2*W-1:0] mon_exp;
    int             mon_edge;
    bit             mon_dz;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no completion", hi, lo);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_edge = exp_edge_q.pop_front();
                mon_dz   = exp_dz_q.pop_front();
                check("result_hi", 64'(hi), 64'(mon_exp[2*W-1:W]));
                check("result_lo", 64'(lo), 64'(mon_exp[W-1:0]));
                check("done_edge", 64'(edge_cnt), 64'(mon_edge));
`ifdef MIPS_MULDIV_DIVZERO_EN
                check("dz_flag", 64'(dz), 64'(mon_dz));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a negedge with busy=0; returns at the negedge after E0.
    task automatic issue(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input bit e_dz,
                         input bit push, input bit hwe, input bit lwe, input logic [W-1:0] wd);
        int lat;
        lat   = (DZ_EN && e_dz) ? 1 : W + 1;
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        hi_we = hwe;
        lo_we = lwe;
        wdata = wd;
        if (push) begin
            exp_q.push_back({e_hi, e_lo});
            exp_edge_q.push_back(edge_cnt + 1 + lat);
            exp_dz_q.push_back(e_dz);
            model_hi = e_hi;
            model_lo = e_lo;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    // Counts busy samples; returns at the first negedge with busy=0.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            n_checks++;
            $display("FAIL wait_idle: got busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    // ---------------- stimulus ----------------
    int nb;
    int done_seen;
    logic [W-1:0] prev_hi, prev_lo;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // MULTU extremes, with busy length
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        check("multu_busy_cycles", 64'(nb), 64'(W + 1));

        // Signed/unsigned directed vectors, issued back to back in done cycles
        issue(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        issue(2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        issue(2'b11, 32'd3, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);

        // Divide by zero, unsigned then signed negative dividend
        issue(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        check("divz_busy_cycles", 64'(nb), DZ_EN ? 64'd1 : 64'(W + 1));
        issue(2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, DIVZ_NEG_LO, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);

        // Start and MTHI/MTLO while busy are ignored
        prev_hi = model_hi;
        prev_lo = model_lo;
        issue(2'b00, 32'd1000, 32'd1000, 32'd0, 32'h000F_4240, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd9;
        b     = 32'd3;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busy_write_ignored_hi", 64'(hi), 64'(prev_hi));
        check("busy_write_ignored_lo", 64'(lo), 64'(prev_lo));
        check("busy_held", 64'(busy), 64'd1);
        wait_idle(nb);

        // Back-to-back start in the done cycle
        issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);
        check("b2b_in_done_cycle", 64'(done), 64'd1);
        issue(2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(nb);

        // MTHI/MTLO together with start: writes land at E0, result overwrites later
        issue(2'b10, 32'd100, 32'd10, 32'd0, 32'd10, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_CAFE);
        check("mt_with_start_hi", 64'(hi), 64'h0000_CAFE);
        check("mt_with_start_lo", 64'(lo), 64'h0000_CAFE);
        wait_idle(nb);
        repeat (2) @(negedge clk);

        // MTHI then MTLO while idle
        hi_we = 1'b1;
        wdata = 32'hAAAA_5555;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'hAAAA_5555);
        check("mthi_lo_kept", 64'(lo), 64'd10);
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h1234_5678);
        check("mtlo_hi_kept", 64'(hi), 64'hAAAA_5555);

        // Reset in the middle of RUN aborts with no result
        issue(2'b00, 32'd3, 32'd4, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
